ic_refill_ctrl: RTL and testbench

- Miss/refill sequencer for the L1 instruction cache between fetch and the memory-side read port.
- On a fetch miss it stalls fetch, invalidates the victim line, requests the line from memory, and writes the returned beats into the data array.
- It then commits the tag and releases fetch.
- Flushes from branch misprediction/redirect abort the refill without corrupting the cache.

---
 rtl/ic_refill_ctrl.sv | 157 +++++++++++++++
 tb/tb_ic_refill_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ic_refill_ctrl.sv
// L1 instruction-cache miss/refill sequencer: stalls fetch, invalidates the victim,
// fetches the line from memory beat by beat, then commits the tag or drains on a flush.
//
//   state  | meaning
//   IDLE   | no refill outstanding; a fetch miss starts one
//   REQ    | line request held on the memory port until acknowledged
//   RECV   | beats written into the data array
//   COMMIT | all beats written; tag written and fetch released
//   DRAIN  | refill aborted; remaining beats swallowed without writes
module ic_refill_ctrl #(
  parameter int ADDR       = 32,
  parameter int INST       = 32,
  parameter int LINE_WORDS = 4,
  localparam int WIDX      = $clog2(LINE_WORDS),
  localparam int OFS       = $clog2(LINE_WORDS * INST / 8)
) (
  input  logic            clk,
  input  logic            reset_,
  input  logic            fetch_valid,
  input  logic [ADDR-1:0] fetch_addr,
  input  logic            fetch_hit,
  input  logic            flush,
  output logic            stall,
  output logic            mem_req,
  output logic [ADDR-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic            mem_rvalid,
  input  logic [INST-1:0] mem_rdata,
  output logic            fill_we,
  output logic [ADDR-1:0] fill_addr,
  output logic [WIDX-1:0] fill_word,
  output logic [INST-1:0] fill_data,
  output logic            tag_inv,
  output logic            tag_we,
  output logic            refill_done,
  output logic            busy
);

  localparam int CW = WIDX + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    RECV   = 3'd2,
    COMMIT = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            abort_q, abort_d;
  logic [ADDR-1:0] line_q, line_d;

  logic            miss;
  logic            last_beat;
  logic [ADDR-1:0] fetch_line;
  logic            unused_ofs;

  assign miss       = fetch_valid & ~fetch_hit & ~flush;
  assign last_beat  = (cnt_q == CW'(LINE_WORDS - 1));
  assign fetch_line = {fetch_addr[ADDR-1:OFS], {OFS{1'b0}}};
  assign unused_ofs = ^fetch_addr[OFS-1:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    abort_d     = abort_q;
    line_d      = line_q;
    mem_req     = 1'b0;
    mem_addr    = '0;
    fill_we     = 1'b0;
    fill_addr   = '0;
    fill_word   = '0;
    fill_data   = '0;
    tag_inv     = 1'b0;
    tag_we      = 1'b0;
    refill_done = 1'b0;

    case (state_q)
      IDLE: begin
        if (miss) begin
          line_d    = fetch_line;
          cnt_d     = '0;
          abort_d   = 1'b0;
          tag_inv   = 1'b1;
          fill_addr = fetch_line;
          state_d   = REQ;
        end
      end
      REQ: begin
        // Request is never withdrawn once raised; a flush only marks the refill dead.
        mem_req   = 1'b1;
        mem_addr  = line_q;
        fill_addr = line_q;
        if (flush) abort_d = 1'b1;
        if (mem_ack) begin
          cnt_d   = '0;
          state_d = (abort_q | flush) ? DRAIN : RECV;
        end
      end
      RECV: begin
        fill_addr = line_q;
        if (flush) begin
          abort_d = 1'b1;
          if (mem_rvalid) cnt_d = cnt_q + CW'(1);
          if (mem_rvalid && last_beat) begin
            abort_d = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = DRAIN;
          end
        end else if (mem_rvalid) begin
          fill_we   = 1'b1;
          fill_word = cnt_q[WIDX-1:0];
          fill_data = mem_rdata;
          cnt_d     = cnt_q + CW'(1);
          if (last_beat) state_d = COMMIT;
        end
      end
      DRAIN: begin
        fill_addr = line_q;
        if (mem_rvalid) begin
          cnt_d = cnt_q + CW'(1);
          if (last_beat) begin
            abort_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      COMMIT: begin
        fill_addr   = line_q;
        tag_we      = 1'b1;
        refill_done = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q != IDLE);
  assign stall = busy | miss;

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      line_q  <= line_d;
    end
  end

endmodule

// File: tb/tb_ic_refill_ctrl.sv
// Bench for ic_refill_ctrl: directed miss/flush/reset scenarios, a refill-level
// reference model compared every cycle, plus literal expectations per scenario.
module tb_ic_refill_ctrl;
  localparam int LW = 4;

  logic        clk = 1'b0;
  logic        reset_;
  logic        fetch_valid, fetch_hit, flush;
  logic [31:0] fetch_addr;
  logic        mem_ack, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        stall, mem_req, fill_we, tag_inv, tag_we, refill_done, busy;
  logic [31:0] mem_addr, fill_addr, fill_data;
  logic [1:0]  fill_word;

  always #5 clk = ~clk;

  ic_refill_ctrl dut (
    .clk(clk), .reset_(reset_),
    .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .fetch_hit(fetch_hit),
    .flush(flush), .stall(stall),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .fill_we(fill_we), .fill_addr(fill_addr), .fill_word(fill_word), .fill_data(fill_data),
    .tag_inv(tag_inv), .tag_we(tag_we), .refill_done(refill_done), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding refill described by what has happened to it so far.
  bit          mon_en = 0;
  bit          m_active, m_acked, m_abort, m_commit;
  logic [31:0] m_line;
  int          m_beats;

  logic        e_stall, e_req, e_we, e_inv, e_twe, e_done, e_busy;
  logic [31:0] e_maddr, e_faddr, e_fdata;
  logic [1:0]  e_fword;
  logic        m_miss;

  int          cyc;
  int          inv_cnt, req_cnt, we_cnt, twe_cnt, done_cnt, stall_cnt, busy_cnt;
  int          inv_cyc, done_cyc;
  logic [31:0] inv_addr, req_addr, twe_addr;
  logic [31:0] wdata_q[$];
  int          widx_q[$];

  always @(negedge clk) begin
    if (mon_en) begin
      m_miss  = fetch_valid & ~fetch_hit & ~flush;
      e_stall = 0; e_req = 0; e_we = 0; e_inv = 0; e_twe = 0; e_done = 0; e_busy = 0;
      e_maddr = '0; e_faddr = '0; e_fdata = '0; e_fword = '0;
      if (!m_active) begin
        e_stall = m_miss;
        e_inv   = m_miss;
        e_faddr = m_miss ? (fetch_addr & ~32'hF) : 32'h0;
      end else begin
        e_busy  = 1;
        e_stall = 1;
        e_faddr = m_line;
        if (m_commit) begin
          e_twe  = 1;
          e_done = 1;
        end else if (!m_acked) begin
          e_req   = 1;
          e_maddr = m_line;
        end else if (mem_rvalid && !m_abort && !flush) begin
          e_we    = 1;
          e_fword = 2'(m_beats);
          e_fdata = mem_rdata;
        end
      end

      chk("stall", stall, e_stall);
      chk("busy", busy, e_busy);
      chk("mem_req", mem_req, e_req);
      chk("mem_addr", mem_addr, e_maddr);
      chk("tag_inv", tag_inv, e_inv);
      chk("fill_addr", fill_addr, e_faddr);
      chk("fill_we", fill_we, e_we);
      chk("fill_word", fill_word, e_fword);
      chk("fill_data", fill_data, e_fdata);
      chk("tag_we", tag_we, e_twe);
      chk("refill_done", refill_done, e_done);

      if (tag_inv)     begin inv_cnt++; inv_addr = fill_addr; inv_cyc = cyc; end
      if (mem_req)     begin req_cnt++; req_addr = mem_addr; end
      if (fill_we)     begin we_cnt++; wdata_q.push_back(fill_data); widx_q.push_back(int'(fill_word)); end
      if (tag_we)      begin twe_cnt++; twe_addr = fill_addr; end
      if (refill_done) begin done_cnt++; done_cyc = cyc; end
      if (stall)       stall_cnt++;
      if (busy)        busy_cnt++;

      if (!reset_) begin
        m_active = 0; m_abort = 0; m_commit = 0; m_acked = 0; m_beats = 0;
      end else if (!m_active) begin
        if (m_miss) begin
          m_active = 1; m_line = fetch_addr & ~32'hF;
          m_acked = 0; m_beats = 0; m_abort = 0; m_commit = 0;
        end
      end else if (m_commit) begin
        m_active = 0;
      end else if (!m_acked) begin
        if (flush) m_abort = 1;
        if (mem_ack) begin m_acked = 1; m_beats = 0; end
      end else begin
        if (flush) m_abort = 1;
        if (mem_rvalid) begin
          m_beats++;
          if (m_beats == LW) begin
            if (m_abort) m_active = 0;
            else         m_commit = 1;
          end
        end
      end
      cyc++;
    end
  end

  task automatic step(input bit fv, input logic [31:0] fa, input bit fh, input bit fl,
                      input bit ack, input bit rv, input logic [31:0] rd);
    fetch_valid = fv; fetch_addr = fa; fetch_hit = fh; flush = fl;
    mem_ack = ack; mem_rvalid = rv; mem_rdata = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    inv_cnt = 0; req_cnt = 0; we_cnt = 0; twe_cnt = 0; done_cnt = 0;
    stall_cnt = 0; busy_cnt = 0; inv_cyc = -1; done_cyc = -1;
    inv_addr = '0; req_addr = '0; twe_addr = '0;
    wdata_q.delete(); widx_q.delete();
  endtask

  task automatic chk_writes(input string nm, input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      chk({nm, "_word"}, (i < widx_q.size())  ? 64'(widx_q[i])  : 64'hX, 64'(i));
      chk({nm, "_data"}, (i < wdata_q.size()) ? 64'(wdata_q[i]) : 64'hX, 64'(base + 32'(i)));
    end
  endtask

  initial begin
    m_active = 0; m_acked = 0; m_abort = 0; m_commit = 0; m_line = '0; m_beats = 0; cyc = 0;
    clear_logs();
    reset_ = 1'b0;
    fetch_valid = 0; fetch_addr = '0; fetch_hit = 0; flush = 0;
    mem_ack = 0; mem_rvalid = 0; mem_rdata = '0;
    @(posedge clk); #1;
    mon_en = 1;
    step(0, 0, 0, 0, 0, 0, 0);
    reset_ = 1'b1;

    // Basic miss, ack after three request cycles, back-to-back beats.
    clear_logs();
    step(1, 32'h1234, 0, 0, 0, 0, 0);
    step(1, 32'h1234, 0, 0, 0, 0, 0);
    step(1, 32'h1234, 0, 0, 0, 0, 0);
    step(1, 32'h1234, 0, 0, 1, 0, 0);
    for (int i = 0; i < LW; i++) step(1, 32'h1234, 0, 0, 0, 1, 32'hA0 + 32'(i));
    step(1, 32'h1234, 1, 0, 0, 0, 0);
    step(1, 32'h1234, 1, 0, 0, 0, 0);
    chk("s1_inv_cnt", inv_cnt, 1);
    chk("s1_inv_addr", inv_addr, 32'h1230);
    chk("s1_req_cnt", req_cnt, 3);
    chk("s1_req_addr", req_addr, 32'h1230);
    chk("s1_we_cnt", we_cnt, 4);
    chk_writes("s1", 32'hA0, LW);
    chk("s1_twe_cnt", twe_cnt, 1);
    chk("s1_twe_addr", twe_addr, 32'h1230);
    chk("s1_done_cnt", done_cnt, 1);
    chk("s1_stall_cnt", stall_cnt, 9);

    // Hit stream.
    clear_logs();
    for (int i = 0; i < 20; i++) step(1, 32'h100 + 32'(4 * i), 1, 0, 0, 0, 0);
    chk("s2_stall_cnt", stall_cnt, 0);
    chk("s2_req_cnt", req_cnt, 0);
    chk("s2_busy_cnt", busy_cnt, 0);

    // Flush while the request is pending: request held, whole line drained.
    clear_logs();
    step(1, 32'h2000, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < LW; i++) step(0, 0, 0, 0, 0, 1, 32'hB0 + 32'(i));
    step(0, 0, 0, 0, 0, 0, 0);
    chk("s3_inv_cnt", inv_cnt, 1);
    chk("s3_req_cnt", req_cnt, 3);
    chk("s3_we_cnt", we_cnt, 0);
    chk("s3_twe_cnt", twe_cnt, 0);
    chk("s3_done_cnt", done_cnt, 0);
    chk("s3_busy_cnt", busy_cnt, 7);

    // Flush coinciding with beat 2.
    clear_logs();
    step(1, 32'h3004, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'hC0);
    step(0, 0, 0, 0, 0, 1, 32'hC1);
    step(0, 0, 0, 1, 0, 1, 32'hC2);
    step(0, 0, 0, 0, 0, 1, 32'hC3);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("s4_inv_addr", inv_addr, 32'h3000);
    chk("s4_we_cnt", we_cnt, 2);
    chk_writes("s4", 32'hC0, 2);
    chk("s4_twe_cnt", twe_cnt, 0);
    chk("s4_done_cnt", done_cnt, 0);
    chk("s4_busy_cnt", busy_cnt, 5);

    // Reset after one received beat; stray beats afterwards ignored.
    clear_logs();
    step(1, 32'h4000, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'hD0);
    reset_ = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0);
    reset_ = 1'b1;
    clear_logs();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 32'hE0 + 32'(i));
    chk("s5_stray_we", we_cnt, 0);
    chk("s5_stray_busy", busy_cnt, 0);
    chk("s5_stray_stall", stall_cnt, 0);

    // Minimum-latency refill after the reset.
    clear_logs();
    step(1, 32'h5008, 0, 0, 0, 0, 0);
    step(1, 32'h5008, 0, 0, 1, 0, 0);
    for (int i = 0; i < LW; i++) step(1, 32'h5008, 0, 0, 0, 1, 32'hF0 + 32'(i));
    step(1, 32'h5008, 1, 0, 0, 0, 0);
    step(1, 32'h5008, 1, 0, 0, 0, 0);
    chk("s5_inv_addr", inv_addr, 32'h5000);
    chk("s5_we_cnt", we_cnt, 4);
    chk_writes("s5", 32'hF0, LW);
    chk("s5_done_cnt", done_cnt, 1);
    chk("s5_latency", done_cyc - inv_cyc + 1, 3 + LW);

    // Miss masked by flush, then a refill with gapped beats and a stray beat in REQ.
    clear_logs();
    step(1, 32'h6000, 0, 1, 0, 0, 0);
    chk("s6_masked_inv", inv_cnt, 0);
    chk("s6_masked_req", req_cnt, 0);
    chk("s6_masked_stall", stall_cnt, 0);
    clear_logs();
    step(1, 32'h6010, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'hDEAD);
    step(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < LW; i++) begin
      step(0, 0, 0, 0, 0, 1, 32'h70 + 32'(i));
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
    end
    chk("s6_inv_addr", inv_addr, 32'h6010);
    chk("s6_we_cnt", we_cnt, 4);
    chk_writes("s6", 32'h70, LW);
    chk("s6_done_cnt", done_cnt, 1);
    chk("s6_twe_addr", twe_addr, 32'h6010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
